device_id_reader: RTL and testbench

Bus-side initiator for the PUF device-ID block (`puf_device_id`). It accepts ENROLL/READ commands from the system controller and checks them against the PUF's `enrolled_flag`. It sequences the PUF's `enroll`/`read_id` handshake with a timeout, then captures the 128-bit ID into a shadow register. Software reads the ID and a status word through a 32-bit, one-cycle-latency register read port.

---
 rtl/device_id_reader_pkg.sv | 38 +++
 rtl/device_id_reader_if.sv | 30 +++
 rtl/device_id_reader.sv | 158 +++++++++++++++
 tb/tb_device_id_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/device_id_reader_pkg.sv
// Shared types and constants for the PUF device-ID reader: FSM states,
// completion error codes, register-map addresses and the status word layout.
package device_id_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_RDY   = 2'd1,
        ST_ISSUE      = 2'd2,
        ST_WAIT_VALID = 2'd3
    } dir_state_t;

    typedef enum logic [1:0] {
        ERR_NONE             = 2'd0,
        ERR_NOT_ENROLLED     = 2'd1,
        ERR_ALREADY_ENROLLED = 2'd2,
        ERR_TIMEOUT          = 2'd3
    } dir_err_t;

    localparam logic OP_READ   = 1'b0;
    localparam logic OP_ENROLL = 1'b1;

    localparam logic [2:0] ADDR_ID0    = 3'd0;
    localparam logic [2:0] ADDR_ID1    = 3'd1;
    localparam logic [2:0] ADDR_ID2    = 3'd2;
    localparam logic [2:0] ADDR_ID3    = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;

    function automatic logic [31:0] status_word(
        input logic     busy,
        input logic     id_valid,
        input logic     enrolled,
        input dir_err_t err,
        input logic     done_sticky
    );
        return {26'd0, busy, id_valid, enrolled, err, done_sticky};
    endfunction

endpackage

// File: rtl/device_id_reader_if.sv
// Command, PUF handshake and register-read signals of the device-ID reader;
// slave is the reader itself, master is the surrounding system and PUF.
interface device_id_reader_if;
    logic         cmd_valid;
    logic         cmd_op;
    logic         cmd_ready;
    logic         cmd_done;
    logic         puf_enroll;
    logic         puf_read_id;
    logic         puf_ready;
    logic         puf_valid;
    logic         puf_enrolled;
    logic [127:0] puf_id;
    logic         rd_en;
    logic [2:0]   rd_addr;
    logic [31:0]  rd_data;
    logic         rd_valid;

    modport slave (
        input  cmd_valid, cmd_op, puf_ready, puf_valid, puf_enrolled, puf_id,
               rd_en, rd_addr,
        output cmd_ready, cmd_done, puf_enroll, puf_read_id, rd_data, rd_valid
    );

    modport master (
        output cmd_valid, cmd_op, puf_ready, puf_valid, puf_enrolled, puf_id,
               rd_en, rd_addr,
        input  cmd_ready, cmd_done, puf_enroll, puf_read_id, rd_data, rd_valid
    );
endinterface

// File: rtl/device_id_reader.sv
// Bus-side initiator for the PUF device-ID block: command FSM with timeout,
// 128-bit ID shadow register and a one-cycle-latency 32-bit read port.
module device_id_reader
    import device_id_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd64
) (
    input  logic              clock,
    input  logic              reset,
    device_id_reader_if.slave bus
);

    dir_state_t   state_q, state_d;
    logic         op_q, op_d;
    logic [31:0]  cnt_q, cnt_d;
    logic [127:0] id_q, id_d;
    logic         id_valid_q, id_valid_d;
    dir_err_t     err_q, err_d;
    logic         done_q, done_d;
    logic         sticky_q, sticky_d;
    logic [31:0]  rd_data_q, rd_data_d;
    logic         rd_valid_q;
    logic         timeout_s;

    assign timeout_s = (cnt_q == (TIMEOUT_CYCLES - 32'd1));

    // Next-state logic for the command sequencer and the ID/err shadow.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        id_d       = id_q;
        id_valid_d = id_valid_q;
        err_d      = err_q;
        done_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d = bus.cmd_op;
                    if ((bus.cmd_op == OP_READ) && !bus.puf_enrolled) begin
                        err_d  = ERR_NOT_ENROLLED;
                        done_d = 1'b1;
                    end else if ((bus.cmd_op == OP_ENROLL) && bus.puf_enrolled) begin
                        err_d  = ERR_ALREADY_ENROLLED;
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = 32'd0;
                        state_d = ST_WAIT_RDY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_RDY: begin
                cnt_d = cnt_q + 32'd1;
                if (timeout_s) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (bus.puf_ready) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_RDY;
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 32'd1;
                if (timeout_s) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_VALID;
                end
            end
            ST_WAIT_VALID: begin
                cnt_d = cnt_q + 32'd1;
                // A capture in the timeout cycle still counts as success.
                if (bus.puf_valid) begin
                    id_d       = bus.puf_id;
                    id_valid_d = 1'b1;
                    err_d      = ERR_NONE;
                    done_d     = 1'b1;
                    state_d    = ST_IDLE;
                end else if (timeout_s) begin
                    err_d   = ERR_TIMEOUT;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_VALID;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register read mux and the completion sticky bit.
    always_comb begin
        rd_data_d = 32'd0;
        if (bus.rd_en) begin
            case (bus.rd_addr)
                ADDR_ID0:    rd_data_d = id_q[31:0];
                ADDR_ID1:    rd_data_d = id_q[63:32];
                ADDR_ID2:    rd_data_d = id_q[95:64];
                ADDR_ID3:    rd_data_d = id_q[127:96];
                ADDR_STATUS: rd_data_d = status_word(state_q != ST_IDLE, id_valid_q,
                                                     bus.puf_enrolled, err_q, sticky_q);
                default:     rd_data_d = 32'd0;
            endcase
        end else begin
            rd_data_d = 32'd0;
        end
        if (done_q) begin
            sticky_d = 1'b1;
        end else if (bus.rd_en && (bus.rd_addr == ADDR_STATUS)) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    // State and shadow registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_READ;
            cnt_q      <= 32'd0;
            id_q       <= 128'd0;
            id_valid_q <= 1'b0;
            err_q      <= ERR_NONE;
            done_q     <= 1'b0;
            sticky_q   <= 1'b0;
            rd_data_q  <= 32'd0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            id_q       <= id_d;
            id_valid_q <= id_valid_d;
            err_q      <= err_d;
            done_q     <= done_d;
            sticky_q   <= sticky_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= bus.rd_en;
        end
    end

    assign bus.cmd_ready   = (state_q == ST_IDLE);
    assign bus.cmd_done    = done_q;
    assign bus.puf_enroll  = (state_q == ST_ISSUE) && (op_q == OP_ENROLL);
    assign bus.puf_read_id = (state_q == ST_ISSUE) && (op_q == OP_READ);
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_device_id_reader.sv
// Randomized scoreboard bench for device_id_reader with a scripted PUF stub.
module tb_device_id_reader;
    import device_id_pkg::*;

    localparam int T = 40;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    device_id_reader_if bif();

    device_id_reader #(.TIMEOUT_CYCLES(T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          at;
        logic [31:0] val;
    } exp_t;

    exp_t q_done[$];
    exp_t q_strb[$];
    exp_t q_rd[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [127:0] dev_id;
    logic [127:0] m_id;
    logic         m_idv, m_enr, m_sticky;
    logic [1:0]   m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] exp_word(input logic [2:0] a, input logic busy);
        case (a)
            3'd0:    return m_id[31:0];
            3'd1:    return m_id[63:32];
            3'd2:    return m_id[95:64];
            3'd3:    return m_id[127:96];
            3'd4:    return {26'd0, busy, m_idv, m_enr, m_err, m_sticky};
            default: return 32'd0;
        endcase
    endfunction

    task automatic issue_rd(input logic [2:0] a, input logic busy);
        exp_t e;
        e.at  = cyc + 1;
        e.val = exp_word(a, busy);
        q_rd.push_back(e);
        bif.rd_en   = 1'b1;
        bif.rd_addr = a;
        if (a == 3'd4) m_sticky = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        issue_rd(a, 1'b0);
        tick();
        bif.rd_en = 1'b0;
    endtask

    task automatic rd_all();
        for (int a = 0; a < 8; a++) begin
            issue_rd(3'(a), 1'b0);
            tick();
        end
        bif.rd_en = 1'b0;
        tick();
    endtask

    // Outcome from the command rules: illegal -> done at 1; otherwise the strobe
    // lands 2+r cycles after accept, valid L later, and the deadline is cycle T.
    task automatic predict(input bit op, input int r, input int L, input bit stuck,
                           output int done_rel, output int strb_rel,
                           output bit cap, output logic [1:0] err);
        cap = 1'b0;
        strb_rel = -1;
        if (!op && !m_enr) begin
            done_rel = 1; err = 2'd1;
        end else if (op && m_enr) begin
            done_rel = 1; err = 2'd2;
        end else begin
            strb_rel = 2 + r;
            if (!stuck && (strb_rel + L <= T)) begin
                done_rel = strb_rel + L + 1; err = 2'd0; cap = 1'b1;
            end else begin
                done_rel = T + 1; err = 2'd3;
            end
        end
    endtask

    task automatic run_cmd(input bit op, input int r, input int L, input bit stuck,
                           input bit poke, input bit rd_cap, input int rst_at);
        int         t0, done_rel, strb_rel, vc;
        bit         cap, inflight;
        logic [1:0] err;
        exp_t       e;
        predict(op, r, L, stuck, done_rel, strb_rel, cap, err);
        t0 = cyc;
        inflight = 1'b0;
        vc = -1;
        e.at = t0 + done_rel; e.val = 32'd0;
        q_done.push_back(e);
        if (strb_rel >= 0) begin
            e.at = t0 + strb_rel; e.val = op ? 32'd2 : 32'd1;
            q_strb.push_back(e);
        end
        for (int c = 0; c <= done_rel; c++) begin
            bif.rd_en     = 1'b0;
            bif.cmd_valid = (c == 0) || (poke && c >= 1 && c <= 4);
            bif.cmd_op    = (c == 0) ? op : ~op;
            if (!inflight && (bif.puf_enroll || bif.puf_read_id)) begin
                inflight = 1'b1;
                vc = c + L;
            end
            bif.puf_ready = (c >= 1 + r) && !inflight;
            bif.puf_valid = inflight && !stuck && (c == vc);
            bif.puf_id    = bif.puf_valid ? dev_id : {$urandom(), $urandom(), $urandom(), $urandom()};
            if (poke && c == 2) chk("cmd_ready_busy", 32'(bif.cmd_ready), 32'd0);
            if (poke && c == 3) issue_rd(3'd4, 1'b1);
            if (rd_cap && c == vc) issue_rd(3'd2, 1'b1);
            if (rst_at >= 0 && c == rst_at - 1) issue_rd(3'd0, 1'b1);
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_cmd_ready", 32'(bif.cmd_ready), 32'd1);
                chk("rst_cmd_done", 32'(bif.cmd_done), 32'd0);
                chk("rst_strobes", {30'd0, bif.puf_enroll, bif.puf_read_id}, 32'd0);
                chk("rst_rd_valid", 32'(bif.rd_valid), 32'd0);
                chk("rst_rd_data", bif.rd_data, 32'd0);
                q_done.delete(); q_strb.delete(); q_rd.delete();
                m_id = 128'd0; m_idv = 1'b0; m_err = 2'd0; m_sticky = 1'b0;
                bif.cmd_valid = 1'b0; bif.puf_valid = 1'b0; bif.rd_en = 1'b0;
                tick();
                reset = 1'b0;
                tick();
                return;
            end
            tick();
        end
        bif.cmd_valid = 1'b0;
        bif.puf_valid = 1'b0;
        bif.rd_en     = 1'b0;
        if (cap) begin
            m_id  = dev_id;
            m_idv = 1'b1;
            if (op) begin
                m_enr = 1'b1;
                bif.puf_enrolled = 1'b1;
            end
        end
        m_err    = err;
        m_sticky = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    always @(negedge clock) begin : mon
        exp_t e;
        if (!reset) begin
            if (bif.cmd_done) begin
                if (q_done.size() == 0) chk("cmd_done_spurious", 32'(bif.cmd_done), 32'd0);
                else begin
                    e = q_done.pop_front();
                    chk("cmd_done_cycle", cyc, e.at);
                end
            end
            if (bif.puf_enroll || bif.puf_read_id) begin
                if (q_strb.size() == 0)
                    chk("strobe_spurious", {30'd0, bif.puf_enroll, bif.puf_read_id}, 32'd0);
                else begin
                    e = q_strb.pop_front();
                    chk("strobe_cycle", cyc, e.at);
                    chk("strobe_kind", {30'd0, bif.puf_enroll, bif.puf_read_id}, e.val);
                end
            end
            if (bif.rd_valid) begin
                if (q_rd.size() == 0) chk("rd_valid_spurious", 32'(bif.rd_valid), 32'd0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_cycle", cyc, e.at);
                    chk("rd_data", bif.rd_data, e.val);
                end
            end
        end
    end

    initial begin
        int sel, r, L;
        bit op, stuck;
        bif.cmd_valid = 1'b0; bif.cmd_op = 1'b0; bif.puf_ready = 1'b0;
        bif.puf_valid = 1'b0; bif.puf_enrolled = 1'b0; bif.puf_id = 128'd0;
        bif.rd_en = 1'b0; bif.rd_addr = 3'd0;
        dev_id = {$urandom(), $urandom(), $urandom(), $urandom()} | 128'h1_0000_0001_0000_0001_0000_0001;
        m_id = 128'd0; m_idv = 1'b0; m_enr = 1'b0; m_sticky = 1'b0; m_err = 2'd0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        chk("reset_outputs", {27'd0, bif.cmd_done, bif.puf_enroll, bif.puf_read_id,
                              bif.rd_valid, 1'b0}, 32'd0);
        chk("reset_rd_data", bif.rd_data, 32'd0);
        reset = 1'b0;
        tick();
        rd_all();

        run_cmd(OP_READ, 0, 2, 1'b0, 1'b0, 1'b0, -1);    // not enrolled
        rd(3'd4);
        run_cmd(OP_ENROLL, 0, 34, 1'b0, 1'b1, 1'b1, -1); // real enrollment
        rd_all();
        run_cmd(OP_ENROLL, 0, 34, 1'b0, 1'b0, 1'b0, -1); // already enrolled
        rd(3'd4);
        rd_all();
        run_cmd(OP_READ, 0, 2, 1'b0, 1'b0, 1'b0, -1);
        rd_all();
        run_cmd(OP_READ, 0, 2, 1'b1, 1'b0, 1'b0, -1);    // stuck PUF
        rd(3'd4);
        run_cmd(OP_READ, 0, T - 2, 1'b0, 1'b0, 1'b0, -1); // valid on the deadline
        rd(3'd4);
        run_cmd(OP_READ, 2, T - 3, 1'b0, 1'b0, 1'b0, -1); // one cycle late
        rd(3'd4);

        for (int i = 0; i < 16; i++) begin
            op    = 1'($urandom_range(0, 1));
            r     = $urandom_range(0, 3);
            sel   = $urandom_range(0, 5);
            stuck = (sel == 5);
            case (sel)
                0:       L = 2;
                1:       L = 34;
                2:       L = T - 2 - r;
                3:       L = T - 1 - r;
                default: L = $urandom_range(1, 8);
            endcase
            run_cmd(op, r, L, stuck, 1'b0, 1'b0, -1);
            rd(3'd4);
            rd(3'($urandom_range(0, 7)));
        end

        run_cmd(OP_READ, 0, 10, 1'b0, 1'b0, 1'b0, 5);    // reset in WAIT_VALID
        rd_all();
        repeat (3) tick();

        chk("pending_done", q_done.size(), 32'd0);
        chk("pending_strobe", q_strb.size(), 32'd0);
        chk("pending_reads", q_rd.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
